// File: rtl/soc_irq_aggregator.sv
// soc_irq_aggregator
//   Collects up to NUM_IRQ peripheral interrupt requests into one CPU irq.
//   Each source is synchronised, captured as level or rising edge into a
//   pending bit, masked, and OR-reduced into a registered irq. A priority
//   vector register gives the lowest-numbered active source.
//
// Ports
//   clk, reset_n          system clock, async active-low reset
//   address[2:0]          slave word address
//   chipselect, write_n   slave select / active-low write strobe
//   writedata[15:0]       write data
//   readdata[15:0]        registered read data (address mux, one cycle later)
//   irq_in[NUM_IRQ-1:0]   async peripheral requests, active-high
//   irq                   combined interrupt, registered
//
// Register map: 0 STATUS (R pend&mask, W1C), 1 RAW (R pend), 2 MASK,
//   3 EDGE (1 = rising edge), 4 VECTOR {valid,11'b0,idx}, 5 SOFT_SET (W1S),
//   6/7 read 0.

// Per-source cell: synchroniser, edge history and pending bit.
module soc_irq_aggregator_bit (
  input  logic clk,
  input  logic reset_n,
  input  logic irq_in,
  input  logic edge_mode,
  input  logic soft_set,
  input  logic w1c,
  output logic pend
);
  logic meta, sync, hist, set;

  // A set in the same cycle as a W1C wins, so an edge is never lost and a
  // still-high level source cannot be cleared.
  assign set = (edge_mode ? (sync & ~hist) : sync) | soft_set;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      hist <= 1'b0;
      pend <= 1'b0;
    end else begin
      meta <= irq_in;
      sync <= meta;
      hist <= sync;
      if (set)      pend <= 1'b1;
      else if (w1c) pend <= 1'b0;
    end
  end
endmodule

module soc_irq_aggregator #(
  parameter int NUM_IRQ = 8,
  parameter int DATA_W  = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [DATA_W-1:0]  writedata,
  output logic [DATA_W-1:0]  readdata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq
);
  localparam logic [2:0] A_STATUS = 3'd0;
  localparam logic [2:0] A_RAW    = 3'd1;
  localparam logic [2:0] A_MASK   = 3'd2;
  localparam logic [2:0] A_EDGE   = 3'd3;
  localparam logic [2:0] A_VECTOR = 3'd4;

  logic               wr;
  logic [NUM_IRQ-1:0] wd, pend, mask_q, edge_q, act, w1c_v, set_v;
  logic               vld;
  logic [3:0]         idx;
  logic [DATA_W-1:0]  rd_d;

  // Data bits above NUM_IRQ are intentionally ignored.
  logic unused_wd;
  assign unused_wd = ^writedata;

  assign wr    = chipselect & ~write_n;
  assign wd    = writedata[NUM_IRQ-1:0];
  assign w1c_v = (wr && address == A_STATUS) ? wd : '0;
  assign set_v = (wr && address == 3'd5)     ? wd : '0;
  assign act   = pend & mask_q;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_src
    soc_irq_aggregator_bit u_bit (
      .clk       (clk),
      .reset_n   (reset_n),
      .irq_in    (irq_in[g]),
      .edge_mode (edge_q[g]),
      .soft_set  (set_v[g]),
      .w1c       (w1c_v[g]),
      .pend      (pend[g])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
      edge_q <= '0;
    end else if (wr) begin
      if (address == A_MASK) mask_q <= wd;
      if (address == A_EDGE) edge_q <= wd;
    end
  end

  // Lowest-numbered active source wins: scan high to low, last hit sticks.
  always_comb begin
    vld = 1'b0;
    idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (act[i]) begin
        vld = 1'b1;
        idx = i[3:0];
      end
    end
  end

  always_comb begin
    rd_d = '0;
    case (address)
      A_STATUS: rd_d[NUM_IRQ-1:0] = act;
      A_RAW:    rd_d[NUM_IRQ-1:0] = pend;
      A_MASK:   rd_d[NUM_IRQ-1:0] = mask_q;
      A_EDGE:   rd_d[NUM_IRQ-1:0] = edge_q;
      A_VECTOR: rd_d = {vld, 11'b0, idx};
      default:  rd_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= rd_d;
      irq      <= |act;
    end
  end
endmodule

// File: tb/tb_soc_irq_aggregator.sv
module tb_soc_irq_aggregator;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [15:0] writedata = '0;
  logic [15:0] readdata;
  logic [7:0]  irq_in = '0;
  logic        irq;

  int tests = 0;
  int fails = 0;

  soc_irq_aggregator #(.NUM_IRQ(8), .DATA_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_in     (irq_in),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // One record = one clock: inputs driven at negedge, outputs checked 1ns
  // after the following posedge.
  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic [7:0]  irqv;
    logic        crd;
    logic [15:0] erd;
    logic        cirq;
    logic        eirq;
    string       name;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic wr, logic [2:0] addr, logic [15:0] wdata,
                              logic [7:0] irqv, logic crd, logic [15:0] erd,
                              logic cirq, logic eirq, string name);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.irqv = irqv;
    v.crd = crd; v.erd = erd; v.cirq = cirq; v.eirq = eirq; v.name = name;
    return v;
  endfunction

  function automatic void add(logic wr, logic [2:0] addr, logic [15:0] wdata,
                              logic [7:0] irqv, logic crd, logic [15:0] erd,
                              logic cirq, logic eirq, string name);
    tbl.push_back(mk(wr, addr, wdata, irqv, crd, erd, cirq, eirq, name));
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_step(vec_t v);
    @(negedge clk);
    chipselect = 1'b1;
    write_n    = ~v.wr;
    address    = v.addr;
    writedata  = v.wdata;
    irq_in     = v.irqv;
    @(posedge clk);
    #1;
    if (v.crd)  chk({v.name, ".rd"}, readdata, v.erd);
    if (v.cirq) chk({v.name, ".irq"}, {15'b0, irq}, {15'b0, v.eirq});
  endtask

  initial begin
    // ---- reset: all registers read 0, irq 0
    for (int a = 0; a < 8; a++) add(0, 3'(a), 0, 0, 1, 16'h0, 1, 0, $sformatf("rst_rd%0d", a));

    // ---- edge capture on source 0
    add(1, 3, 16'h0001, 0, 0, 0, 0, 0, "");
    add(1, 2, 16'h0001, 0, 0, 0, 0, 0, "");
    add(0, 1, 0, 8'h01, 0, 0, 0, 0, "");                 // sampled here
    add(0, 1, 0, 8'h00, 0, 0, 0, 0, "");
    add(0, 1, 0, 8'h00, 0, 0, 1, 0, "edge_lat2");       // pending, irq not yet
    add(0, 4, 0, 8'h00, 1, 16'h8000, 1, 1, "edge_lat3"); // irq 3 edges later
    add(1, 0, 16'h0001, 0, 0, 0, 1, 1, "w1c_edge");
    add(0, 0, 0, 0, 1, 16'h0000, 1, 0, "edge_cleared");
    // hold source 0 high 20 cycles: pends once, W1C then stays clear
    for (int i = 0; i < 3; i++) add(0, 1, 0, 8'h01, 0, 0, 0, 0, "");
    add(0, 1, 0, 8'h01, 1, 16'h0001, 0, 0, "hold_pend");
    add(1, 0, 16'h0001, 8'h01, 0, 0, 0, 0, "");
    for (int i = 0; i < 15; i++) add(0, 1, 0, 8'h01, 1, 16'h0000, 0, 0, "hold_once");
    for (int i = 0; i < 3; i++) add(0, 1, 0, 8'h00, 0, 0, 0, 0, "");

    // ---- level mode on source 2
    add(1, 3, 16'h0000, 0, 0, 0, 0, 0, "");
    add(1, 2, 16'h0004, 0, 0, 0, 0, 0, "");
    for (int i = 0; i < 3; i++) add(0, 1, 0, 8'h04, 0, 0, 0, 0, "");
    add(0, 1, 0, 8'h04, 1, 16'h0004, 1, 1, "lvl_pend");
    add(0, 1, 0, 8'h04, 0, 0, 0, 0, "");
    add(0, 1, 0, 8'h04, 0, 0, 0, 0, "");
    add(1, 0, 16'h0004, 8'h04, 0, 0, 0, 0, "");
    add(0, 1, 0, 8'h04, 1, 16'h0004, 1, 1, "lvl_w1c_high");
    for (int i = 0; i < 3; i++) add(0, 1, 0, 8'h00, 0, 0, 0, 0, "");
    add(1, 0, 16'h0004, 0, 0, 0, 1, 1, "lvl_w1c_edge");
    add(0, 1, 0, 0, 1, 16'h0000, 1, 0, "lvl_cleared");

    // ---- mask and priority with sources 3 and 5
    add(1, 3, 16'h0028, 0, 0, 0, 0, 0, "");
    add(1, 2, 16'h0000, 0, 0, 0, 0, 0, "");
    add(0, 1, 0, 8'h28, 0, 0, 0, 0, "");
    add(0, 1, 0, 8'h00, 0, 0, 0, 0, "");
    add(0, 1, 0, 8'h00, 0, 0, 0, 0, "");
    add(0, 1, 0, 8'h00, 1, 16'h0028, 1, 0, "masked_raw");
    add(0, 0, 0, 8'h00, 1, 16'h0000, 1, 0, "masked_status");
    add(1, 2, 16'h0028, 0, 0, 0, 1, 0, "unmask_edge");
    add(0, 4, 0, 0, 1, 16'h8003, 1, 1, "vector3");
    add(1, 0, 16'h0008, 0, 0, 0, 0, 0, "");
    add(0, 4, 0, 0, 1, 16'h8005, 1, 1, "vector5");

    // ---- simultaneous rise + W1C on source 1, soft set on source 7
    add(1, 5, 16'h0002, 0, 0, 0, 0, 0, "");
    add(1, 3, 16'h002A, 0, 0, 0, 0, 0, "");
    add(0, 1, 0, 8'h02, 0, 0, 0, 0, "");
    add(0, 1, 0, 8'h02, 0, 0, 0, 0, "");
    add(1, 0, 16'h0002, 8'h02, 0, 0, 0, 0, "");         // rise this cycle
    add(0, 1, 0, 8'h00, 1, 16'h0022, 0, 0, "rise_beats_w1c");
    add(1, 5, 16'h0080, 0, 0, 0, 0, 0, "");
    add(0, 1, 0, 0, 1, 16'h00A2, 1, 1, "soft_set_raw");
    add(0, 5, 0, 0, 1, 16'h0000, 0, 0, "soft_set_reads0");
    add(0, 0, 0, 0, 1, 16'h0020, 0, 0, "soft_set_status");
    add(0, 6, 0, 0, 1, 16'h0000, 0, 0, "addr6");

    // ---- reset sequence
    #1;
    chk("rst_async_irq", {15'b0, irq}, 16'h0);
    chk("rst_async_rd", readdata, 16'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    foreach (tbl[i]) run_step(tbl[i]);

    // ---- reset mid-operation
    run_step(mk(1, 2, 16'h00FF, 0, 0, 0, 0, 0, ""));
    run_step(mk(1, 5, 16'h00FF, 0, 0, 0, 0, 0, ""));
    run_step(mk(0, 1, 0, 0, 1, 16'h00FF, 1, 1, "pre_reset"));
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_irq", {15'b0, irq}, 16'h0);
    chk("midrst_rd", readdata, 16'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) run_step(mk(0, 1, 0, 0, 1, 16'h0000, 1, 0, "post_reset"));
    run_step(mk(0, 2, 0, 0, 1, 16'h0000, 0, 0, "post_reset_mask"));

    chipselect = 1'b0;
    write_n    = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
